// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared AXI4 types for the write master and its helpers.
//   resp_e      : BRESP / RRESP encodings
//   burst_e     : AxBURST encodings
//   wm_state_e  : write-master FSM states
//   AXI_MAX_LEN : largest AxLEN value (256-beat burst)
//   is_err_resp : true for a completion that should count as an error
// ---------------------------------------------------------------------------
package axi_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } wm_state_e;

    localparam int AXI_MAX_LEN = 255;

    function automatic logic is_err_resp(input logic [1:0] resp, input logic id_err);
        return (resp == SLVERR) || (resp == DECERR) || id_err;
    endfunction

endpackage

// File: rtl/axi_skid_buf.sv
// ---------------------------------------------------------------------------
// axi_skid_buf
// One-entry register slice with valid/ready on both sides. The held entry
// stays stable while out_valid_o && !out_ready_i, and a new entry may be
// loaded in the same cycle the held one drains.
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   in_valid_i / in_ready_o : upstream handshake, in_data_i payload
//   out_valid_o/out_ready_i : downstream handshake, out_data_o payload
// ---------------------------------------------------------------------------
module axi_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    assign in_ready_o  = out_ready_i || !valid_q;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    // NOTE: the payload register is reset too so the bus outputs never show
    // X after reset; a reset-free datapath would be legal AXI but noisier.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready_o) begin
            valid_q <= in_valid_i;
            if (in_valid_i) begin
                data_q <= in_data_i;
            end
        end
    end

endmodule

// File: rtl/axi_write_master.sv
// ---------------------------------------------------------------------------
// axi_write_master
// AXI4 write-channel master: one outstanding INCR burst. Takes a command
// (addr/len/id) and a write-data stream, drives AW then W, then waits on B.
//   PCLK, PRESET           : clock, asynchronous active-high reset
//   cmd_*                  : command request (valid/ready, addr, len, id)
//   wd_*                   : write-data stream (valid/ready, data, strb)
//   AW*/W*/B*              : AXI4 write address, data and response channels
//   done, done_resp,
//   done_id_err            : one-cycle completion pulse with response info
//   busy                   : FSM not in IDLE
// Optional: define AXI_WRITE_MASTER_ERR_CNT_EN to add err_cnt[7:0], a
// saturating count of completions with SLVERR/DECERR or a BID mismatch.
// ---------------------------------------------------------------------------
module axi_write_master
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [7:0]          cmd_len,
    input  logic [ID_W-1:0]     cmd_id,
    input  logic                wd_valid,
    output logic                wd_ready,
    input  logic [DATA_W-1:0]   wd_data,
    input  logic [DATA_W/8-1:0] wd_strb,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic [7:0]          AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic [ID_W-1:0]     AWID,
    output logic                WVALID,
    input  logic                WREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WLAST,
    input  logic                BVALID,
    output logic                BREADY,
    input  logic [1:0]          BRESP,
    input  logic [ID_W-1:0]     BID,
    output logic                done,
    output logic [1:0]          done_resp,
    output logic                done_id_err,
    output logic                busy
`ifdef AXI_WRITE_MASTER_ERR_CNT_EN
    ,
    output logic [7:0]          err_cnt
`endif
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(AXI_MAX_LEN + 1);

    wm_state_e         state_q;
    logic [CNT_W-1:0]  cnt_q;         // W handshakes completed in this burst
    logic              cmd_ready_q;
    logic              awvalid_q;
    logic [ADDR_W-1:0] awaddr_q;
    logic [7:0]        awlen_q;
    logic [ID_W-1:0]   awid_q;
    logic              bready_q;
    logic              done_q;
    logic [1:0]        done_resp_q;
    logic              done_id_err_q;
    logic              skid_in_ready;

    assign AWSIZE  = 3'($clog2(STRB_W));
    assign AWBURST = INCR;

    // The beat sitting in the slice is beat number cnt_q, so it is the last
    // one exactly when cnt_q has reached AWLEN.
    assign WLAST = WVALID && (cnt_q == awlen_q);

    // Refill the slice only in DATA and never once the last beat is loaded,
    // so data belonging to the next burst is left in the stream.
    assign wd_ready = (state_q == DATA) && skid_in_ready && !WLAST;

    axi_skid_buf #(
        .WIDTH(DATA_W + STRB_W)
    ) u_w_skid (
        .clk_i      (PCLK),
        .rst_i      (PRESET),
        .in_valid_i (wd_valid && wd_ready),
        .in_ready_o (skid_in_ready),
        .in_data_i  ({wd_data, wd_strb}),
        .out_valid_o(WVALID),
        .out_ready_i(WREADY),
        .out_data_o ({WDATA, WSTRB})
    );

`ifdef AXI_WRITE_MASTER_ERR_CNT_EN
    logic [7:0] err_cnt_q;
    assign err_cnt = err_cnt_q;
`endif

    // NOTE: all state here is sequential, so every assignment is
    // non-blocking; later assignments in the same cycle override earlier ones.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b0;
            awvalid_q     <= 1'b0;
            awaddr_q      <= '0;
            awlen_q       <= '0;
            awid_q        <= '0;
            bready_q      <= 1'b0;
            done_q        <= 1'b0;
            done_resp_q   <= '0;
            done_id_err_q <= 1'b0;
`ifdef AXI_WRITE_MASTER_ERR_CNT_EN
            err_cnt_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        awaddr_q    <= cmd_addr;
                        awlen_q     <= cmd_len;
                        awid_q      <= cmd_id;
                        awvalid_q   <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= ADDR;
                    end
                end
                ADDR: begin
                    if (AWREADY) begin
                        awvalid_q <= 1'b0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (WVALID && WREADY) begin
                        if (WLAST) begin
                            cnt_q    <= '0;
                            bready_q <= 1'b1;
                            state_q  <= RESP;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                RESP: begin
                    if (BVALID) begin
                        bready_q      <= 1'b0;
                        done_q        <= 1'b1;
                        done_resp_q   <= BRESP;
                        done_id_err_q <= (BID != awid_q);
                        cmd_ready_q   <= 1'b1;
                        state_q       <= IDLE;
`ifdef AXI_WRITE_MASTER_ERR_CNT_EN
                        if (is_err_resp(BRESP, BID != awid_q) && (err_cnt_q != 8'hFF)) begin
                            err_cnt_q <= err_cnt_q + 8'd1;
                        end
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign AWVALID     = awvalid_q;
    assign AWADDR      = awaddr_q;
    assign AWLEN       = awlen_q;
    assign AWID        = awid_q;
    assign BREADY      = bready_q;
    assign done        = done_q;
    assign done_resp   = done_resp_q;
    assign done_id_err = done_id_err_q;
    assign busy        = (state_q != IDLE);

endmodule
